// File: rtl/fetch_seq_if.sv
// fetch_seq_if -- bundle of all fetch_seq handshake and bus signals.
//
// master modport : the fetch sequencer (drives the memory request and the
//                  decoded instruction, receives start/pc, memory data and
//                  the execute-stage ready).
// slave modport  : the environment around the sequencer (control, memory
//                  and execute stage seen as one).
//
// Signals
//   start, pc              fetch request and instruction address
//   mem_req, mem_addr      byte read request / address
//   mem_ack, mem_rdata     byte read completion / data
//   instr_valid/ready      decoded-instruction handshake
//   icode, ifun, rA, rB    decoded fields
//   valC, valP             constant and next-pc
//   instr_err, imem_err    invalid encoding / fetch timeout
//   busy                   sequencer not idle
interface fetch_seq_if;
   logic        start;
   logic [63:0] pc;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic [63:0] valC;
   logic [63:0] valP;
   logic        instr_err;
   logic        imem_err;
   logic        busy;

   modport master (
      input  start, pc, mem_ack, mem_rdata, instr_ready,
      output mem_req, mem_addr, instr_valid, icode, ifun, rA, rB,
             valC, valP, instr_err, imem_err, busy
   );

   modport slave (
      output start, pc, mem_ack, mem_rdata, instr_ready,
      input  mem_req, mem_addr, instr_valid, icode, ifun, rA, rB,
             valC, valP, instr_err, imem_err, busy
   );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq -- byte-serial instruction fetch and decode sequencer.
//
// On an accepted start the sequencer reads the instruction one byte at a
// time from a byte-wide memory (request held until ack), works out the
// instruction length from the first byte, and once all bytes are in (or a
// byte times out) presents the decoded instruction until the execute stage
// takes it.
//
// Ports
//   clk    in  single clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    fetch_seq_if.master (start/pc in, memory byte bus, decoded
//          instruction out with instr_valid/instr_ready handshake, errors,
//          busy)
//
// Parameter
//   TIMEOUT  cycles without mem_ack tolerated on one byte (1..255)
module fetch_seq #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   fetch_seq_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Counter value at which the current no-ack cycle is the last one allowed.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   function automatic logic [3:0] instr_len(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
         4'h7, 4'h8:             instr_len = 4'd9;
         4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
         default:                instr_len = 4'd1;
      endcase
   endfunction

   function automatic logic ifun_bad(input logic [3:0] ic, input logic [3:0] fn);
      case (ic)
         4'h6:       ifun_bad = (fn > 4'd3);
         4'h2, 4'h7: ifun_bad = (fn > 4'd6);
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                     ifun_bad = (fn != 4'd0);
         default:    ifun_bad = 1'b1;
      endcase
   endfunction

   // Control / output registers
   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic [63:0] mem_addr_q, mem_addr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        busy_q, busy_d;
   logic [3:0]  icode_q, icode_d;
   logic [3:0]  ifun_q, ifun_d;
   logic [3:0]  ra_q, ra_d;
   logic [3:0]  rb_q, rb_d;
   logic [63:0] valc_q, valc_d;
   logic [63:0] valp_q, valp_d;
   logic        instr_err_q, instr_err_d;
   logic        imem_err_q, imem_err_d;

   // Datapath registers
   logic [63:0]     pc_q, pc_d;
   logic [9:0][7:0] bytes_q, bytes_d;
   logic [3:0]      idx_q, idx_d;
   logic [7:0]      tcnt_q, tcnt_d;

   logic       fetch_ack;
   logic       last_byte;
   logic       timed_out;
   logic [3:0] idx_inc;

   // Decode of the byte buffer as it will be after this cycle
   logic [3:0]  dec_icode, dec_ifun, dec_len, dec_ra, dec_rb;
   logic        dec_regs;
   logic [63:0] dec_valc, dec_valp;
   logic        dec_err;

   assign fetch_ack = (state_q == FETCH) && bus.mem_ack;
   assign idx_inc   = idx_q + 4'd1;

   always_comb begin
      pc_d    = pc_q;
      bytes_d = bytes_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;
      if (state_q == IDLE && bus.start) begin
         pc_d    = bus.pc;
         bytes_d = '0;
         idx_d   = 4'd0;
         tcnt_d  = 8'd0;
      end else if (state_q == FETCH) begin
         if (bus.mem_ack) begin
            bytes_d[idx_q] = bus.mem_rdata;
            idx_d          = idx_inc;
            tcnt_d         = 8'd0;
         end else begin
            tcnt_d = tcnt_q + 8'd1;
         end
      end
   end

   // Byte 0 of bytes_d is the freshly acked byte on the first ack, so the
   // length is already known when deciding whether that ack was the last.
   assign dec_icode = bytes_d[0][7:4];
   assign dec_ifun  = bytes_d[0][3:0];
   assign dec_len   = instr_len(dec_icode);
   assign dec_regs  = (dec_len == 4'd2) || (dec_len == 4'd10);
   assign dec_ra    = dec_regs ? bytes_d[1][7:4] : 4'hF;
   assign dec_rb    = dec_regs ? bytes_d[1][3:0] : 4'hF;
   assign dec_valc  = (dec_len == 4'd9)  ? bytes_d[8:1] :
                      (dec_len == 4'd10) ? bytes_d[9:2] : 64'd0;
   assign dec_valp  = pc_q + {60'd0, dec_len};
   assign dec_err   = ifun_bad(dec_icode, dec_ifun);

   assign last_byte = fetch_ack && (idx_inc == dec_len);
   assign timed_out = (state_q == FETCH) && !bus.mem_ack && (tcnt_q == TMO_LAST);

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      instr_valid_d = instr_valid_q;
      busy_d        = busy_q;
      icode_d       = icode_q;
      ifun_d        = ifun_q;
      ra_d          = ra_q;
      rb_d          = rb_q;
      valc_d        = valc_q;
      valp_d        = valp_q;
      instr_err_d   = instr_err_q;
      imem_err_d    = imem_err_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = FETCH;
               busy_d     = 1'b1;
               mem_req_d  = 1'b1;
               mem_addr_d = bus.pc;
            end
         end
         FETCH: begin
            if (last_byte || timed_out) begin
               state_d       = HOLD;
               mem_req_d     = 1'b0;
               instr_valid_d = 1'b1;
               icode_d       = dec_icode;
               ifun_d        = dec_ifun;
               ra_d          = dec_ra;
               rb_d          = dec_rb;
               valc_d        = dec_valc;
               valp_d        = dec_valp;
               instr_err_d   = dec_err;
               imem_err_d    = timed_out;
            end else if (fetch_ack) begin
               // Next byte is requested back-to-back with the ack.
               mem_addr_d = pc_q + {60'd0, idx_inc};
            end
         end
         HOLD: begin
            if (bus.instr_ready) begin
               state_d       = IDLE;
               instr_valid_d = 1'b0;
               busy_d        = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= 64'd0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         icode_q       <= 4'd0;
         ifun_q        <= 4'd0;
         ra_q          <= 4'hF;
         rb_q          <= 4'hF;
         valc_q        <= 64'd0;
         valp_q        <= 64'd0;
         instr_err_q   <= 1'b0;
         imem_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_valid_q <= instr_valid_d;
         busy_q        <= busy_d;
         icode_q       <= icode_d;
         ifun_q        <= ifun_d;
         ra_q          <= ra_d;
         rb_q          <= rb_d;
         valc_q        <= valc_d;
         valp_q        <= valp_d;
         instr_err_q   <= instr_err_d;
         imem_err_q    <= imem_err_d;
      end
   end

   // Pure data: always re-initialised when a fetch is accepted.
   always_ff @(posedge clk) begin
      pc_q    <= pc_d;
      bytes_q <= bytes_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.busy        = busy_q;
   assign bus.icode       = icode_q;
   assign bus.ifun        = ifun_q;
   assign bus.rA          = ra_q;
   assign bus.rB          = rb_q;
   assign bus.valC        = valc_q;
   assign bus.valP        = valp_q;
   assign bus.instr_err   = instr_err_q;
   assign bus.imem_err    = imem_err_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq -- self-checking bench for fetch_seq.
// A byte memory responder with programmable wait states answers the fetch
// requests; expected decoded instructions come from a reference decoder
// and are queued when a fetch is started, then popped and compared when
// instr_valid appears.
module tb_fetch_seq;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
      logic        ierr;
      logic        merr;
   } res_t;

   typedef logic [7:0] bq_t[$];

   localparam res_t RST = res_t'({4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0});

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_seq_if bus();

   fetch_seq #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   res_t sb[$];

   logic [7:0]  mem [logic [63:0]];
   bit          mem_en = 1'b1;
   int          mem_delay = 0;
   bit          man_ack = 1'b0;
   logic [7:0]  man_data = 8'h00;
   bit          addr_moved = 1'b0;

   // Memory responder: acks after mem_delay wait cycles per byte, or drives
   // the manual ack/data values when disabled.
   initial begin
      int          wcnt;
      logic [63:0] waddr;
      wcnt = 0;
      waddr = 64'd0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (!mem_en) begin
            bus.mem_ack = man_ack;
            bus.mem_rdata = man_data;
            wcnt = 0;
         end else if (bus.mem_req === 1'b1) begin
            if (wcnt > 0 && bus.mem_addr != waddr) addr_moved = 1'b1;
            if (wcnt >= mem_delay) begin
               bus.mem_ack = 1'b1;
               bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
               wcnt = 0;
            end else begin
               bus.mem_ack = 1'b0;
               if (wcnt == 0) waddr = bus.mem_addr;
               wcnt++;
            end
         end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic res_t model(input logic [63:0] pc, input bq_t b, input int nf, input bit tmo);
      logic [7:0] g [10];
      res_t r;
      int   len;
      for (int i = 0; i < 10; i++) g[i] = (i < nf && i < b.size()) ? b[i] : 8'h00;
      r.icode = g[0][7:4];
      r.ifun  = g[0][3:0];
      case (r.icode)
         4'h2, 4'h6, 4'hA, 4'hB: len = 2;
         4'h7, 4'h8:             len = 9;
         4'h3, 4'h4, 4'h5:       len = 10;
         default:                len = 1;
      endcase
      if (r.icode >= 4'hC)                      r.ierr = 1'b1;
      else if (r.icode == 4'h6)                 r.ierr = (r.ifun > 4'd3);
      else if (r.icode == 4'h2 || r.icode == 4'h7) r.ierr = (r.ifun > 4'd6);
      else                                      r.ierr = (r.ifun != 4'd0);
      if (len == 2 || len == 10) begin
         r.ra = g[1][7:4];
         r.rb = g[1][3:0];
      end else begin
         r.ra = 4'hF;
         r.rb = 4'hF;
      end
      r.valc = 64'd0;
      if (len >= 9)
         for (int j = 0; j < 8; j++) r.valc[8*j +: 8] = g[len - 8 + j];
      r.valp = pc + 64'(len);
      r.merr = tmo;
      return r;
   endfunction

   function automatic res_t grab();
      return {bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP, bus.instr_err, bus.imem_err};
   endfunction

   task automatic load(input logic [63:0] a, input bq_t b);
      foreach (b[i]) mem[a + 64'(i)] = b[i];
   endtask

   // Pulse start for one cycle, then wait (bounded) for instr_valid.
   // lat is the cycle count from the start cycle, -1 if it never came.
   task automatic fetch_one(input logic [63:0] a, output res_t obs, output int lat);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.pc = a;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         @(negedge clk);
         if (bus.instr_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
      obs = grab();
   endtask

   task automatic handshake();
      bus.instr_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b1;
      bus.pc = 64'h55;
      bus.instr_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (grab() !== RST) begin
         errors++;
         $display("FAIL reset_fields got %h want %h", grab(), RST);
      end
      checks++;
      if ({bus.mem_req, bus.mem_addr, bus.instr_valid, bus.busy} !== 67'd0) begin
         errors++;
         $display("FAIL reset_ctrl got req=%b addr=%h vld=%b busy=%b want all 0",
                  bus.mem_req, bus.mem_addr, bus.instr_valid, bus.busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle got busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_nop();
      bq_t  b;
      res_t obs, exp;
      int   lat;
      b = '{8'h10};
      load(64'h100, b);
      mem_delay = 0;
      sb.push_back(model(64'h100, b, 1, 1'b0));
      fetch_one(64'h100, obs, lat);
      exp = sb.pop_front();
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL nop_latency got %0d want 2", lat);
      end
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL nop_result got %h want %h", obs, exp);
      end
      handshake();
   endtask

   task automatic test_irmovq();
      bq_t  b;
      res_t obs, exp;
      int   lat;
      b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      load(64'h0, b);
      mem_delay = 0;
      sb.push_back(model(64'h0, b, 10, 1'b0));
      fetch_one(64'h0, obs, lat);
      exp = sb.pop_front();
      checks++;
      if (lat != 11) begin
         errors++;
         $display("FAIL irmovq_latency got %0d want 11", lat);
      end
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL irmovq_result got %h want %h", obs, exp);
      end
      checks++;
      if (obs.valc !== 64'h0102030405060708 || obs.rb !== 4'h3 || obs.valp !== 64'hA) begin
         errors++;
         $display("FAIL irmovq_fields got valC=%h rB=%h valP=%h want 0102030405060708/3/a",
                  obs.valc, obs.rb, obs.valp);
      end
      handshake();
   endtask

   task automatic test_jxx_err();
      bq_t  b;
      res_t obs, exp;
      int   lat;
      b = '{8'h77, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(64'h200, b);
      mem_delay = 3;
      addr_moved = 1'b0;
      sb.push_back(model(64'h200, b, 9, 1'b0));
      fetch_one(64'h200, obs, lat);
      exp = sb.pop_front();
      checks++;
      if (lat != 37) begin
         errors++;
         $display("FAIL jxx_latency got %0d want 37", lat);
      end
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL jxx_result got %h want %h", obs, exp);
      end
      checks++;
      if (obs.ierr !== 1'b1 || obs.valp !== 64'h209) begin
         errors++;
         $display("FAIL jxx_err_valp got err=%b valP=%h want 1/209", obs.ierr, obs.valp);
      end
      checks++;
      if (addr_moved !== 1'b0) begin
         errors++;
         $display("FAIL jxx_addr_stable got moved=%b want 0", addr_moved);
      end
      mem_delay = 0;
      handshake();
   endtask

   task automatic test_timeout();
      bq_t  b;
      res_t obs, exp;
      int   lat, reqc;
      b = {};
      mem_en = 1'b0;
      man_ack = 1'b0;
      sb.push_back(model(64'h500, b, 0, 1'b1));
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.pc = 64'h500;
      lat = -1;
      reqc = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         @(negedge clk);
         if (bus.mem_req === 1'b1) reqc++;
         if (bus.instr_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
      obs = grab();
      exp = sb.pop_front();
      checks++;
      if (reqc != 16 || lat != 17) begin
         errors++;
         $display("FAIL timeout_cycles got req_cycles=%0d valid_at=%0d want 16/17", reqc, lat);
      end
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL timeout_result got %h want %h", obs, exp);
      end
      handshake();
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_to_idle got vld=%b busy=%b want 0/0", bus.instr_valid, bus.busy);
      end
      mem_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      bq_t  b;
      res_t obs, exp;
      int   lat;
      bit   seen;
      b = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(64'h300, b);
      mem_delay = 2;
      seen = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.pc = 64'h300;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 && bus.mem_addr === 64'h304) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rst_mid_reach_byte4 got seen=0 want 1");
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_en = 1'b0;
      man_ack = 1'b1;
      man_data = 8'hAA;
      @(negedge clk);
      checks++;
      if (grab() !== RST || {bus.mem_req, bus.mem_addr, bus.instr_valid, bus.busy} !== 67'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs got %h req=%b addr=%h vld=%b busy=%b want %h and 0s",
                  grab(), bus.mem_req, bus.mem_addr, bus.instr_valid, bus.busy, RST);
      end
      @(posedge clk);
      #1;
      man_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (grab() !== RST || {bus.mem_req, bus.mem_addr, bus.instr_valid, bus.busy} !== 67'd0) begin
         errors++;
         $display("FAIL rst_mid_late_ack got %h req=%b addr=%h vld=%b busy=%b want %h and 0s",
                  grab(), bus.mem_req, bus.mem_addr, bus.instr_valid, bus.busy, RST);
      end
      mem_en = 1'b1;
      mem_delay = 0;
      b = '{8'h90};
      load(64'h400, b);
      sb.push_back(model(64'h400, b, 1, 1'b0));
      fetch_one(64'h400, obs, lat);
      exp = sb.pop_front();
      checks++;
      if (lat != 2 || obs !== exp) begin
         errors++;
         $display("FAIL rst_mid_refetch got lat=%0d %h want 2 %h", lat, obs, exp);
      end
      handshake();
   endtask

   task automatic test_hold_stall();
      bq_t  b;
      res_t obs, exp;
      int   lat;
      b = '{8'h20, 8'h45};
      load(64'hFFFF_FFFF_FFFF_FFFF, b);
      mem_delay = 0;
      sb.push_back(model(64'hFFFF_FFFF_FFFF_FFFF, b, 2, 1'b0));
      fetch_one(64'hFFFF_FFFF_FFFF_FFFF, obs, lat);
      exp = sb.pop_front();
      checks++;
      if (lat != 3 || obs !== exp) begin
         errors++;
         $display("FAIL wrap_fetch got lat=%0d %h want 3 %h", lat, obs, exp);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         bus.start = (i == 1 || i == 3);
         bus.pc = 64'h777;
         @(negedge clk);
         checks++;
         if (grab() !== exp || bus.instr_valid !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable cycle %0d got %h vld=%b req=%b want %h 1 0",
                     i, grab(), bus.instr_valid, bus.mem_req, exp);
         end
      end
      bus.start = 1'b1;
      bus.instr_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL hold_handshake got vld=%b busy=%b req=%b want 0/0/0",
                  bus.instr_valid, bus.busy, bus.mem_req);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL start_in_handshake_ignored got busy=%b req=%b want 0/0", bus.busy, bus.mem_req);
      end
   endtask

   task automatic test_back_to_back();
      bq_t         prog, sub;
      res_t        obs, exp;
      int          lat, off;
      logic [63:0] base, a;
      prog = '{8'h60, 8'h23,
               8'h65, 8'h12,
               8'h27, 8'h45,
               8'hC0,
               8'hA0, 8'h4F,
               8'h80, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
               8'h50, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      base = 64'h1000;
      load(base, prog);
      off = 0;
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sub.delete();
         for (int j = 0; j < 10; j++) sub.push_back(prog[off + j]);
         a = base + 64'(off);
         sb.push_back(model(a, sub, 10, 1'b0));
         mem_delay = int'($urandom_range(0, 2));
         fetch_one(a, obs, lat);
         exp = sb.pop_front();
         checks++;
         if (lat < 0 || obs !== exp) begin
            errors++;
            $display("FAIL b2b instr %0d at %h got lat=%0d %h want %h", k, a, lat, obs, exp);
         end
         off = off + int'(exp.valp - a);
      end
      @(negedge clk);
      bus.instr_ready = 1'b0;
      mem_delay = 0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drained got %0d left want 0", sb.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.pc = 64'd0;
      bus.instr_ready = 1'b0;
      test_reset();
      test_nop();
      test_irmovq();
      test_jxx_err();
      test_timeout();
      test_reset_mid();
      test_hold_stall();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum cycles fetch_seq waits for mem_ack on one byte before aborting; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  fetch request; sampled only in IDLE.
REQ-005 pc  in  64  instruction address; captured when start accepted.
REQ-006 mem_req  out  1  byte read request; held high until mem_ack.
REQ-007 mem_addr  out  64  byte address; stable while mem_req high.
REQ-008 mem_ack  in  1  read complete; mem_rdata valid this cycle.
REQ-009 mem_rdata  in  8  returned byte.
REQ-010 instr_valid  out  1  decoded instruction available.
REQ-011 instr_ready  in  1  execute stage accepts instruction.
REQ-012 icode, ifun  out  4 each  byte 0 high/low nibble.
REQ-013 rA, rB  out  4 each  byte 1 high/low nibble; 4'hF when no register byte.
REQ-014 valC  out  64  little-endian constant; 0 when absent.
REQ-015 valP  out  64  pc + instruction length, modulo 2^64.
REQ-016 instr_err  out  1  invalid icode/ifun; imem_err  out  1  fetch timeout.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 States: IDLE, FETCH, HOLD; FETCH fetches bytes, HOLD presents the result.
REQ-019 IDLE: start=1 -> capture pc, clear byte index idx=0 and timeout counter, go FETCH next cycle; start while busy is ignored.
REQ-020 FETCH: mem_req=1, mem_addr=pc+idx (64-bit wrap, e.g. pc=all-ones, idx=1 -> 0).
REQ-021 mem_ack in FETCH stores mem_rdata into byte slot idx and increments idx; mem_ack outside FETCH is ignored.
REQ-022 mem_req deasserts in the cycle after the final byte's ack; a new byte request follows immediately (no idle cycle) otherwise.
REQ-023 Length from icode (byte 0): 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C..F -> 1 with instr_err=1.
REQ-024 Byte layout: len 2 -> byte1 = rA:rB; len 9 -> valC = bytes 1..8; len 10 -> byte1 = rA:rB, valC = bytes 2..9; byte n maps to valC[8(n-k)+7 : 8(n-k)], lowest byte first.
REQ-025 ifun validity: 6 requires ifun<=3; 2 and 7 require ifun<=6; all other valid icodes require ifun=0; violation sets instr_err=1 but length still follows icode.
REQ-026 Timeout counter counts cycles in FETCH without mem_ack, clearing on each ack; reaching TIMEOUT -> imem_err=1, mem_req low next cycle, go HOLD with icode/ifun/rA/rB/valC/valP as captured so far (unfetched bytes 0).
REQ-027 After last byte ack -> HOLD next cycle with instr_valid=1; all outputs stable until handshake.
REQ-028 HOLD: instr_valid=1 and instr_ready=1 in the same cycle -> handshake; go IDLE next cycle, instr_valid=0.
REQ-029 start in the handshake cycle is ignored; earliest new acceptance is the following cycle in IDLE.
REQ-030 instr_ready outside HOLD has no effect.
REQ-031 Latency: start at cycle 0 with zero-wait memory (ack in the cycle mem_req first rises) -> instr_valid at cycle 1+len.

Reset
REQ-032 reset=1 at any clock edge forces IDLE regardless of state; takes priority over start, mem_ack and instr_ready in the same cycle.
REQ-033 Reset values: mem_req=0, mem_addr=0, instr_valid=0, busy=0, instr_err=0, imem_err=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0.
REQ-034 Reset mid-FETCH: mem_req low the cycle after reset; a late mem_ack after reset is discarded.

Verification
REQ-035 nop at pc=0x100, zero-wait memory: bytes 10 -> instr_valid at cycle 2, icode=1, ifun=0, rA=rB=F, valP=0x101.
REQ-036 irmovq at pc=0: bytes 30 F3 08 07 06 05 04 03 02 01 -> rB=3, valC=0x0102030405060708, valP=0x0A, instr_valid at cycle 11.
REQ-037 jXX byte 77 with ifun 7, ack delayed 3 cycles per byte -> instr_err=1, valP=pc+9, mem_addr stable during waits.
REQ-038 No ack with TIMEOUT=16 -> mem_req high exactly 16 cycles, imem_err=1, instr_valid=1, then instr_ready=1 -> IDLE.
REQ-039 reset during byte 4 of a rmmovq fetch, late ack after reset -> all outputs at reset values, next start fetches from new pc.
REQ-040 HOLD with instr_ready low 5 cycles, start pulsed -> outputs stable and start ignored; handshake -> IDLE next cycle.
